multi_book_engine: RTL
======================

# multi_book_engine

Multi-instrument successor to the single-book engine: accepts decoded ITCH order messages (add, delete, execute, cancel) over a valid/ready handshake, keeps a direct-mapped order map shared by all books, and keeps a price-level array per book per side. After each successful message it rescans the affected book and publishes that book's top-of-book. It sits between the ITCH parser and the strategy/output stage.

## Interface
- NUM_BOOKS, 4: number of instruments; power of two, ≥2.
- ORDER_MAP_DEPTH, 1024: order map entries; power of two.
- LEVELS, 8: price levels per side per book.
- clkIn  in  1  sole clock.
- rstIn  in  1  asynchronous, active-low reset.
- msgValidIn  in  1  message valid.
- msgReadyOut  out  1  engine can accept a message.
- msgTypeIn  in  2  0 add, 1 delete, 2 execute, 3 cancel.
- refNumIn  in  64  order reference number.
- locateIn  in  16  stock locate; its low log2(NUM_BOOKS) bits select the book.
- priceIn  in  32  add price.
- sharesIn  in  32  add/execute/cancel shares.
- buySellIn  in  1  1 = buy (add only).
- topValidOut  out  1  one-cycle publish strobe.
- topBookOut  out  log2(NUM_BOOKS)  book being published.
- topBuyOut  out  bookLevelType  best bid {price, shares}.
- topSellOut  out  bookLevelType  best ask {price, shares}.
- errValidOut  out  1  one-cycle error strobe.
- errCodeOut  out  2  0 UNKNOWN_REF, 1 COLLISION, 2 BOOK_FULL, 3 BAD_LOCATE.

## Operation
- FSM states: IDLE, LOOKUP, UPDATE, SCAN, PUBLISH, ERR. msgReadyOut = 1 only in IDLE. Input fields are captured on valid&ready.
- IDLE: if locateIn ≥ NUM_BOOKS, go to ERR(BAD_LOCATE); otherwise go to LOOKUP.
- LOOKUP: read map[refNum[log2(DEPTH)-1:0]]. Each entry holds {valid, full refNum tag, book, side, price, remaining shares}.
  - Add with a valid slot: ERR(COLLISION).
  - Delete/execute/cancel with an invalid slot or tag mismatch: ERR(UNKNOWN_REF).
- UPDATE, add: find the same-price level on the side and add shares; otherwise use the lowest-index empty level (shares = 0). If no level is available, go to ERR(BOOK_FULL) and leave the map unwritten. On success, write the map entry.
- UPDATE, delete: subtract the remaining shares from the level and invalidate the map entry.
- UPDATE, execute/cancel: reduce = min(sharesIn, remaining). Subtract reduce from both the level and the entry. If remaining reaches 0, invalidate the entry. Over-execution is clamped and raises no error.
- A level whose shares reach 0 becomes empty, and its price is cleared to 0.
- SCAN: walk levels 0..LEVELS-1 of the book, one per cycle.
  - Best bid = max price with nonzero shares.
  - Best ask = min price with nonzero shares.
  - On equal prices, the lower index wins.
  - An empty side yields {0,0}.
- PUBLISH: register the top outputs, pulse topValidOut, go to IDLE.
- ERR: pulse errValidOut with the code, go to IDLE. Books, map and top outputs are unchanged.
- The book for delete/execute/cancel comes from the map entry, not from locateIn.
- Share arithmetic is 32-bit. A level add that overflows saturates at 2^32-1.

## Timing
- Accept at cycle T. LOOKUP T+1, UPDATE T+2, SCAN T+3..T+2+LEVELS, PUBLISH T+3+LEVELS. msgReadyOut returns at T+4+LEVELS.
- Map-check errors: errValidOut at T+2, ready at T+3.
- BOOK_FULL: errValidOut at T+3, ready at T+4.
- BAD_LOCATE: errValidOut at T+1, ready at T+2.
- Map payload is a 1-cycle-read RAM. Map valid bits and level arrays are flops.
- Reset (rstIn low, any time, including mid-message):
  - Abort and go to IDLE.
  - All outputs go to 0, including msgReadyOut.
  - All map valid bits and levels clear.
  - msgReadyOut = 1 in the first clkIn edge after release.
- topBuyOut/topSellOut/topBookOut hold their values between publishes.
- Valid may drop without acceptance. Input fields are don't-care when valid is low.

## Structure
- pkg gains:
  - msgTypeEnum.
  - errCodeEnum.
  - mapEntryType {valid, tag[63:0], book, buySell, price, shares}.
  - Reuse of the existing bookLevelType.
- Sub-module: price_level_array. It holds NUM_BOOKS×2×LEVELS entries and provides match/free-slot search, update, and an indexed read port for SCAN. The map and FSM stay in the top.

## Test plan
- Add ref 5, book 1, buy, 100@1000 → at T+3+LEVELS: topValidOut, topBookOut 1, topBuyOut {1000,100}, topSellOut {0,0}.
- Add ref 6, book 1, buy, 50@1000, then add ref 7, book 1, buy, 20@1010 → topBuyOut {1000,150}, then {1010,20}.
- Execute ref 7 with 30 shares → clamped; topBuyOut {1000,150}; ref 7 freed; a later delete of ref 7 → errCodeOut 0 at T+2.
- Add ref 5+ORDER_MAP_DEPTH while ref 5 is live → errCodeOut 1; book unchanged.
- LEVELS+1 distinct sell prices in book 0 → last add gives errCodeOut 2; previous top ask unchanged.
- Assert rstIn low during SCAN, release → no publish; msgReadyOut 1 one edge after release; add ref 5 accepted without COLLISION.

Source files
------------

// File: rtl/multi_book_engine_pkg.sv
// multi_book_engine_pkg
// Shared sizing constants, message/error encodings, order-map entry layout,
// price level layout, engine FSM state encoding and a saturating adder used
// by the level array.
package multi_book_engine_pkg;

    localparam int NUM_BOOKS       = 4;
    localparam int ORDER_MAP_DEPTH = 1024;
    localparam int LEVELS          = 8;

    localparam int BOOK_W = $clog2(NUM_BOOKS);
    localparam int MAP_AW = $clog2(ORDER_MAP_DEPTH);
    localparam int LVL_W  = $clog2(LEVELS);

    typedef enum logic [1:0] {
        MSG_ADD     = 2'd0,
        MSG_DELETE  = 2'd1,
        MSG_EXECUTE = 2'd2,
        MSG_CANCEL  = 2'd3
    } msgTypeEnum;

    typedef enum logic [1:0] {
        ERR_UNKNOWN_REF = 2'd0,
        ERR_COLLISION   = 2'd1,
        ERR_BOOK_FULL   = 2'd2,
        ERR_BAD_LOCATE  = 2'd3
    } errCodeEnum;

    typedef struct packed {
        logic [31:0] price;
        logic [31:0] shares;
    } bookLevelType;

    typedef struct packed {
        logic              valid;
        logic [63:0]       tag;
        logic [BOOK_W-1:0] book;
        logic              buySell;
        logic [31:0]       price;
        logic [31:0]       shares;
    } mapEntryType;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_UPDATE  = 3'd2,
        ST_SCAN    = 3'd3,
        ST_PUBLISH = 3'd4,
        ST_ERR     = 3'd5
    } engineStateEnum;

    // 32-bit add that clamps at 2^32-1 instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/multi_book_engine_price_level_array.sv
// price_level_array
// Holds NUM_BOOKS x 2 sides x LEVELS price levels in flops. A level is empty
// when its shares are zero (its price is then zero as well).
// Ports:
//   clk, rst_n             clock, async active-low reset (clears all levels)
//   key_book/side/price    search key for match / free-slot lookup and update
//   upd_en, upd_add        apply an update: add shares (merge or new level) or
//                          subtract shares from the matching level
//   upd_shares             share amount of the update
//   full                   key has no matching level and no empty level
//   rd_book, rd_idx        indexed read port used while scanning a book
//   rd_buy, rd_sell        level rd_idx of both sides of rd_book
module price_level_array
    import multi_book_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BOOK_W-1:0] key_book,
    input  logic              key_side,
    input  logic [31:0]       key_price,
    input  logic              upd_en,
    input  logic              upd_add,
    input  logic [31:0]       upd_shares,
    output logic              full,
    input  logic [BOOK_W-1:0] rd_book,
    input  logic [LVL_W-1:0]  rd_idx,
    output bookLevelType      rd_buy,
    output bookLevelType      rd_sell
);

    // Side index 1 is buy, 0 is sell.
    bookLevelType lvl [NUM_BOOKS][2][LEVELS];

    logic             match_found;
    logic             free_found;
    logic [LVL_W-1:0] match_idx;
    logic [LVL_W-1:0] free_idx;
    logic [LVL_W-1:0] tgt_idx;
    bookLevelType     cur;
    bookLevelType     new_lvl;
    logic             do_write;

    // Walk from the top index down so the lowest matching/free index is the
    // one left standing.
    always_comb begin
        match_found = 1'b0;
        free_found  = 1'b0;
        match_idx   = '0;
        free_idx    = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (lvl[key_book][key_side][i].shares != 32'd0 &&
                lvl[key_book][key_side][i].price == key_price) begin
                match_found = 1'b1;
                match_idx   = LVL_W'(i);
            end
            if (lvl[key_book][key_side][i].shares == 32'd0) begin
                free_found = 1'b1;
                free_idx   = LVL_W'(i);
            end
        end
    end

    assign full = !match_found && !free_found;

    always_comb begin
        tgt_idx = match_found ? match_idx : free_idx;
        cur     = lvl[key_book][key_side][tgt_idx];
        new_lvl = cur;
        if (upd_add) begin
            new_lvl.price  = key_price;
            new_lvl.shares = sat_add32(match_found ? cur.shares : 32'd0, upd_shares);
        end else begin
            new_lvl.shares = (cur.shares > upd_shares) ? cur.shares - upd_shares : 32'd0;
        end
        // A drained level is fully cleared so the scan sees {0,0}.
        if (new_lvl.shares == 32'd0) begin
            new_lvl = '0;
        end
        do_write = upd_en && (upd_add ? !full : match_found);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BOOKS; b++) begin
                for (int s = 0; s < 2; s++) begin
                    for (int i = 0; i < LEVELS; i++) begin
                        lvl[b][s][i] <= '0;
                    end
                end
            end
        end else if (do_write) begin
            lvl[key_book][key_side][tgt_idx] <= new_lvl;
        end
    end

    assign rd_buy  = lvl[rd_book][1][rd_idx];
    assign rd_sell = lvl[rd_book][0][rd_idx];

endmodule

// File: rtl/multi_book_engine.sv
// multi_book_engine
// Applies decoded ITCH add/delete/execute/cancel messages to a shared
// direct-mapped order map and per-book price levels, then rescans the touched
// book and publishes its best bid / best ask.
// Ports:
//   clkIn, rstIn            clock, async active-low reset
//   msgValidIn/msgReadyOut  message handshake
//   msgTypeIn, refNumIn, locateIn, priceIn, sharesIn, buySellIn  message fields
//   topValidOut             one-cycle publish strobe
//   topBookOut, topBuyOut, topSellOut  published book and its best levels (held)
//   errValidOut, errCodeOut one-cycle error strobe and code
//   dbg_state               current FSM state
//
// Handshake: a message transfers on a clkIn edge where msgValidIn and
// msgReadyOut are both high; all fields are captured on that edge. Ready is
// high only while idle, so the producer may drop valid at any time before a
// transfer without effect, and fields are ignored while valid is low.
module multi_book_engine
    import multi_book_engine_pkg::*;
(
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              msgValidIn,
    output logic              msgReadyOut,
    input  logic [1:0]        msgTypeIn,
    input  logic [63:0]       refNumIn,
    input  logic [15:0]       locateIn,
    input  logic [31:0]       priceIn,
    input  logic [31:0]       sharesIn,
    input  logic              buySellIn,
    output logic              topValidOut,
    output logic [BOOK_W-1:0] topBookOut,
    output bookLevelType      topBuyOut,
    output bookLevelType      topSellOut,
    output logic              errValidOut,
    output logic [1:0]        errCodeOut,
    output engineStateEnum    dbg_state
);

    engineStateEnum state, next_state;

    // Held low through reset and set on the first edge after release, so
    // ready stays low while reset is asserted.
    logic out_live;

    msgTypeEnum        msg_type_q;
    logic [63:0]       ref_q;
    logic [BOOK_W-1:0] book_q;
    logic [31:0]       price_q;
    logic [31:0]       shares_q;
    logic              side_q;
    errCodeEnum        err_code_q;

    logic [BOOK_W-1:0] scan_book_q;
    logic [LVL_W-1:0]  scan_idx;
    bookLevelType      acc_buy, acc_sell;
    bookLevelType      buy_fold, sell_fold;

    // Order map: valid bits in flops, payload in a 1-cycle-read RAM.
    logic [ORDER_MAP_DEPTH-1:0] map_valid;
    mapEntryType                map_ram [ORDER_MAP_DEPTH];
    mapEntryType                rd_data;
    logic [MAP_AW-1:0]          map_idx;
    logic [MAP_AW-1:0]          rd_addr;

    logic              accept;
    logic              is_add;
    logic              hit;
    logic [31:0]       reduce;
    logic [31:0]       remaining;
    logic [BOOK_W-1:0] key_book;
    logic              key_side;
    logic [31:0]       key_price;
    logic [31:0]       upd_shares;
    logic              lvl_full;
    logic              lvl_upd_en;
    bookLevelType      rd_buy, rd_sell;

    logic        map_we;
    logic        map_set;
    logic        map_clr;
    mapEntryType map_wdata;
    logic        err_load;
    errCodeEnum  err_next;

    assign msgReadyOut = out_live && (state == ST_IDLE);
    assign accept      = msgValidIn && msgReadyOut;
    assign topValidOut = (state == ST_PUBLISH);
    assign errValidOut = (state == ST_ERR);
    assign errCodeOut  = (state == ST_ERR) ? err_code_q : 2'd0;
    assign dbg_state   = state;

    assign map_idx = ref_q[MAP_AW-1:0];
    // The RAM is addressed from the live input while idle so the entry is
    // already available in LOOKUP; afterwards it stays on the captured ref.
    assign rd_addr = (state == ST_IDLE) ? refNumIn[MAP_AW-1:0] : map_idx;

    assign is_add = (msg_type_q == MSG_ADD);
    assign hit    = map_valid[map_idx] && rd_data.valid && (rd_data.tag == ref_q);

    // Non-add messages work on the book/side/price recorded in the map.
    assign key_book  = is_add ? book_q  : rd_data.book;
    assign key_side  = is_add ? side_q  : rd_data.buySell;
    assign key_price = is_add ? price_q : rd_data.price;

    always_comb begin
        reduce = rd_data.shares;
        if (msg_type_q == MSG_EXECUTE || msg_type_q == MSG_CANCEL) begin
            reduce = (shares_q < rd_data.shares) ? shares_q : rd_data.shares;
        end
    end

    assign remaining  = rd_data.shares - reduce;
    assign upd_shares = is_add ? shares_q : reduce;

    price_level_array u_levels (
        .clk        (clkIn),
        .rst_n      (rstIn),
        .key_book   (key_book),
        .key_side   (key_side),
        .key_price  (key_price),
        .upd_en     (lvl_upd_en),
        .upd_add    (is_add),
        .upd_shares (upd_shares),
        .full       (lvl_full),
        .rd_book    (scan_book_q),
        .rd_idx     (scan_idx),
        .rd_buy     (rd_buy),
        .rd_sell    (rd_sell)
    );

    // Strict compares keep the lower index on equal prices.
    always_comb begin
        buy_fold  = acc_buy;
        sell_fold = acc_sell;
        if (rd_buy.shares != 32'd0 &&
            (acc_buy.shares == 32'd0 || rd_buy.price > acc_buy.price)) begin
            buy_fold = rd_buy;
        end
        if (rd_sell.shares != 32'd0 &&
            (acc_sell.shares == 32'd0 || rd_sell.price < acc_sell.price)) begin
            sell_fold = rd_sell;
        end
    end

    always_comb begin
        next_state = state;
        lvl_upd_en = 1'b0;
        map_we     = 1'b0;
        map_set    = 1'b0;
        map_clr    = 1'b0;
        map_wdata  = '0;
        err_load   = 1'b0;
        err_next   = ERR_UNKNOWN_REF;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (locateIn >= 16'(NUM_BOOKS)) begin
                        next_state = ST_ERR;
                        err_load   = 1'b1;
                        err_next   = ERR_BAD_LOCATE;
                    end else begin
                        next_state = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                if (is_add && map_valid[map_idx]) begin
                    next_state = ST_ERR;
                    err_load   = 1'b1;
                    err_next   = ERR_COLLISION;
                end else if (!is_add && !hit) begin
                    next_state = ST_ERR;
                    err_load   = 1'b1;
                    err_next   = ERR_UNKNOWN_REF;
                end else begin
                    next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (is_add && lvl_full) begin
                    next_state = ST_ERR;
                    err_load   = 1'b1;
                    err_next   = ERR_BOOK_FULL;
                end else begin
                    next_state = ST_SCAN;
                    lvl_upd_en = 1'b1;
                    case (msg_type_q)
                        MSG_ADD: begin
                            map_we    = 1'b1;
                            map_set   = 1'b1;
                            map_wdata = '{valid: 1'b1, tag: ref_q, book: book_q,
                                          buySell: side_q, price: price_q,
                                          shares: shares_q};
                        end
                        MSG_DELETE: begin
                            map_clr = 1'b1;
                        end
                        default: begin
                            if (remaining == 32'd0) begin
                                map_clr = 1'b1;
                            end else begin
                                map_we           = 1'b1;
                                map_wdata        = rd_data;
                                map_wdata.shares = remaining;
                            end
                        end
                    endcase
                end
            end
            ST_SCAN: begin
                if (scan_idx == LVL_W'(LEVELS - 1)) begin
                    next_state = ST_PUBLISH;
                end
            end
            ST_PUBLISH: next_state = ST_IDLE;
            ST_ERR:     next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (map_we) begin
            map_ram[map_idx] <= map_wdata;
        end
        rd_data <= map_ram[rd_addr];
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state       <= ST_IDLE;
            out_live    <= 1'b0;
            map_valid   <= '0;
            msg_type_q  <= MSG_ADD;
            ref_q       <= '0;
            book_q      <= '0;
            price_q     <= '0;
            shares_q    <= '0;
            side_q      <= 1'b0;
            err_code_q  <= ERR_UNKNOWN_REF;
            scan_book_q <= '0;
            scan_idx    <= '0;
            acc_buy     <= '0;
            acc_sell    <= '0;
            topBookOut  <= '0;
            topBuyOut   <= '0;
            topSellOut  <= '0;
        end else begin
            state    <= next_state;
            out_live <= 1'b1;

            if (accept) begin
                msg_type_q <= msgTypeEnum'(msgTypeIn);
                ref_q      <= refNumIn;
                book_q     <= locateIn[BOOK_W-1:0];
                price_q    <= priceIn;
                shares_q   <= sharesIn;
                side_q     <= buySellIn;
            end

            if (err_load) begin
                err_code_q <= err_next;
            end

            if (map_set) begin
                map_valid[map_idx] <= 1'b1;
            end else if (map_clr) begin
                map_valid[map_idx] <= 1'b0;
            end

            if (state == ST_UPDATE && next_state == ST_SCAN) begin
                scan_book_q <= key_book;
                scan_idx    <= '0;
                acc_buy     <= '0;
                acc_sell    <= '0;
            end

            if (state == ST_SCAN) begin
                acc_buy  <= buy_fold;
                acc_sell <= sell_fold;
                scan_idx <= scan_idx + 1'b1;
                if (scan_idx == LVL_W'(LEVELS - 1)) begin
                    topBuyOut  <= buy_fold;
                    topSellOut <= sell_fold;
                    topBookOut <= scan_book_q;
                end
            end
        end
    end

endmodule
